// File: rtl/mmio_pkg.sv
// Shared MMIO definitions: device address map, bus stage state and the
// request bundle passed from each requester into the arbiter.
package mmio_pkg;

  // Input devices (the only addresses that are safe to read through the bus)
  localparam logic [31:0] ADDR_SWITCH_LO = 32'hffff_ff00;
  localparam logic [31:0] ADDR_SWITCH_HI = 32'hffff_ff04;
  localparam logic [31:0] ADDR_BUTTON_0  = 32'hffff_ff14;
  localparam logic [31:0] ADDR_BUTTON_1  = 32'hffff_ff18;
  localparam logic [31:0] ADDR_BUTTON_2  = 32'hffff_ff1c;
  localparam logic [31:0] ADDR_BUTTON_3  = 32'hffff_ff20;
  localparam logic [31:0] ADDR_BUTTON_4  = 32'hffff_ff24;

  // Output devices (written on any address match, so never read them)
  localparam logic [31:0] ADDR_LED       = 32'hffff_ff0c;
  localparam logic [31:0] ADDR_SEG       = 32'hffff_ff10;

  // VGA console pages, matched on address bits [31:12]
  localparam logic [19:0] VGA_CHAR_PAGE  = 20'hffffe;
  localparam logic [19:0] VGA_COLOR_PAGE = 20'hffffd;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACTIVE
  } bus_state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
  } mmio_req_t;

  // True for addresses whose read has no side effect on any device.
  function automatic logic is_readable(input logic [31:0] address);
    case (address)
      ADDR_SWITCH_LO, ADDR_SWITCH_HI,
      ADDR_BUTTON_0, ADDR_BUTTON_1, ADDR_BUTTON_2,
      ADDR_BUTTON_3, ADDR_BUTTON_4: is_readable = 1'b1;
      default:                      is_readable = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mmio_rr_grant.sv
// Two-way grant: round-robin on a 1-bit LastGrant pointer, or fixed priority
// for requester 0. Grants are combinational from the valid inputs.
module mmio_rr_grant #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic last_grant;

  // Pick at most one requester; a lone valid requester always wins.
  // NOTE: the default assignment first keeps this block latch-free.
  always_comb begin
    grant = 2'b00;
    if (FIXED_PRIO) begin
      if (valid[0])      grant = 2'b01;
      else if (valid[1]) grant = 2'b10;
    end else begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Advance the pointer only on an accepted transfer; reset favours req 0.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= 1'b1;
    else if (|grant)
      last_grant <= grant[1];
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Shares the MMIO device port between the CPU (req 0) and the VGA console
// engine (req 1). Address/WriteData come from flops so every device sees a
// full stable period; read data returns to the owner one cycle later.
module mmio_bus_arbiter
  import mmio_pkg::*;
#(
  parameter logic [31:0] IDLE_ADDR  = 32'h0000_0000,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter logic [31:0] MMIO_BASE  = 32'hffff_d000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req0Valid,
  input  logic        Req0Write,
  input  logic [31:0] Req0Address,
  input  logic [31:0] Req0WriteData,
  output logic        Req0Ready,
  output logic        Req0RespValid,
  output logic [31:0] Req0ReadData,
  input  logic        Req1Valid,
  input  logic        Req1Write,
  input  logic [31:0] Req1Address,
  input  logic [31:0] Req1WriteData,
  output logic        Req1Ready,
  output logic        Req1RespValid,
  output logic [31:0] Req1ReadData,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] DataIo
);

  logic [1:0] grant;
  mmio_req_t  req0, req1, sel;
  logic       accept;
  logic       forward;

  bus_state_t state;
  logic       owner;
  logic       is_read;
  logic       forwarded;
  logic [31:0] resp_data;

  assign req0 = '{write: Req0Write, address: Req0Address, wdata: Req0WriteData};
  assign req1 = '{write: Req1Write, address: Req1Address, wdata: Req1WriteData};

  mmio_rr_grant #(.FIXED_PRIO(FIXED_PRIO)) u_grant (
    .clk   (clk),
    .reset (reset),
    .valid ({Req1Valid, Req0Valid}),
    .grant (grant)
  );

  assign Req0Ready = grant[0];
  assign Req1Ready = grant[1];
  assign accept    = |grant;

  // Forward only decoded MMIO addresses, and reads only where a read cannot
  // trigger a device write (the devices have no write enable).
  always_comb begin
    sel     = grant[1] ? req1 : req0;
    forward = (sel.address >= MMIO_BASE) && (sel.write || is_readable(sel.address));
  end

  // Registered bus stage: drive the accepted request or park the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BUS_IDLE;
      owner     <= 1'b0;
      is_read   <= 1'b0;
      forwarded <= 1'b0;
      Address   <= IDLE_ADDR;
      WriteData <= '0;
    end else if (accept) begin
      state     <= BUS_ACTIVE;
      owner     <= grant[1];
      is_read   <= !sel.write;
      forwarded <= forward;
      Address   <= forward ? sel.address : IDLE_ADDR;
      WriteData <= (forward && sel.write) ? sel.wdata : '0;
    end else begin
      state     <= BUS_IDLE;
      Address   <= IDLE_ADDR;
      WriteData <= '0;
    end
  end

  assign resp_data = (is_read && forwarded) ? DataIo : '0;

  // Response: one-cycle pulse to the owner of the transaction just finished;
  // ReadData holds between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Req0RespValid <= 1'b0;
      Req1RespValid <= 1'b0;
      Req0ReadData  <= '0;
      Req1ReadData  <= '0;
    end else begin
      Req0RespValid <= (state == BUS_ACTIVE) && !owner;
      Req1RespValid <= (state == BUS_ACTIVE) && owner;
      if (state == BUS_ACTIVE) begin
        if (owner) Req1ReadData <= resp_data;
        else       Req0ReadData <= resp_data;
      end
    end
  end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed self-checking bench: a round-robin instance and a fixed-priority
// instance share the same stimulus.
module tb_mmio_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r0_write, r1_valid, r1_write;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata, data_io;

  logic        r0_ready, r0_rvalid, r1_ready, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata, bus_addr, bus_wdata;

  logic        f0_ready, f0_rvalid, f1_ready, f1_rvalid;
  logic [31:0] f0_rdata, f1_rdata, f_addr, f_wdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmio_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .Req0Valid(r0_valid), .Req0Write(r0_write), .Req0Address(r0_addr),
    .Req0WriteData(r0_wdata), .Req0Ready(r0_ready), .Req0RespValid(r0_rvalid),
    .Req0ReadData(r0_rdata),
    .Req1Valid(r1_valid), .Req1Write(r1_write), .Req1Address(r1_addr),
    .Req1WriteData(r1_wdata), .Req1Ready(r1_ready), .Req1RespValid(r1_rvalid),
    .Req1ReadData(r1_rdata),
    .Address(bus_addr), .WriteData(bus_wdata), .DataIo(data_io)
  );

  mmio_bus_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .Req0Valid(r0_valid), .Req0Write(r0_write), .Req0Address(r0_addr),
    .Req0WriteData(r0_wdata), .Req0Ready(f0_ready), .Req0RespValid(f0_rvalid),
    .Req0ReadData(f0_rdata),
    .Req1Valid(r1_valid), .Req1Write(r1_write), .Req1Address(r1_addr),
    .Req1WriteData(r1_wdata), .Req1Ready(f1_ready), .Req1RespValid(f1_rvalid),
    .Req1ReadData(f1_rdata),
    .Address(f_addr), .WriteData(f_wdata), .DataIo(data_io)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_valid = 0; r0_write = 0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 0; r1_write = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  initial begin
    reset = 1'b1;
    data_io = '0;
    idle_inputs();
    tick();
    tick();
    // Reset state
    check("rst_addr",    bus_addr,  32'h0);
    check("rst_wdata",   bus_wdata, 32'h0);
    check("rst_r0_rv",   r0_rvalid, 0);
    check("rst_r1_rv",   r1_rvalid, 0);
    check("rst_r0_rd",   r0_rdata,  32'h0);
    check("rst_r1_rd",   r1_rdata,  32'h0);
    reset = 1'b0;
    tick();

    // Single read from the switch port
    r0_valid = 1; r0_write = 0; r0_addr = 32'hffff_ff00; data_io = 32'h0000_005a;
    #1 check("rd_r0_ready", r0_ready, 1);
    tick();
    r0_valid = 0;
    check("rd_addr",      bus_addr,  32'hffff_ff00);
    check("rd_wdata",     bus_wdata, 32'h0);
    check("rd_rv_early",  r0_rvalid, 0);
    tick();
    check("rd_r0_rv",     r0_rvalid, 1);
    check("rd_r0_rd",     r0_rdata,  32'h5a);
    check("rd_r1_rv",     r1_rvalid, 0);
    check("rd_addr_park", bus_addr,  32'h0);
    tick();
    check("rd_rv_drop",   r0_rvalid, 0);
    check("rd_rd_hold",   r0_rdata,  32'h5a);

    // Contention from a fresh reset: RR alternates 0,1,0,1; fixed keeps req 0
    reset = 1'b1; #1 reset = 1'b0;
    r0_valid = 1; r0_write = 1; r0_addr = 32'hffff_ff0c; r0_wdata = 32'h11;
    r1_valid = 1; r1_write = 1; r1_addr = 32'hffff_e005; r1_wdata = 32'h41;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready0", r0_ready, (i % 2 == 0));
      check("rr_ready1", r1_ready, (i % 2 == 1));
      check("fp_ready0", f0_ready, 1);
      check("fp_ready1", f1_ready, 0);
      tick();
      check("rr_addr",  bus_addr,  (i % 2 == 0) ? 32'hffff_ff0c : 32'hffff_e005);
      check("rr_wdata", bus_wdata, (i % 2 == 0) ? 32'h11 : 32'h41);
      check("fp_addr",  f_addr,    32'hffff_ff0c);
      if (i > 0) begin
        check("rr_r0_rv", r0_rvalid, (i % 2 == 0) ? 0 : 1);
        check("rr_r1_rv", r1_rvalid, (i % 2 == 0) ? 1 : 0);
      end
    end
    r0_valid = 0;
    #1 check("fp_r1_ready_after", f1_ready, 1);
    check("rr_r1_ready_alone", r1_ready, 1);
    tick();
    r1_valid = 0;
    check("fp_addr_r1",   f_addr,    32'hffff_e005);
    check("rr_last_r1_rv", r1_rvalid, 1);
    tick();
    tick();

    // Forwarded read by req 1 sets a nonzero ReadData baseline
    r1_valid = 1; r1_write = 0; r1_addr = 32'hffff_ff04; data_io = 32'h77;
    tick();
    r1_valid = 0;
    check("r1rd_addr", bus_addr, 32'hffff_ff04);
    tick();
    check("r1rd_rv",   r1_rvalid, 1);
    check("r1rd_rd",   r1_rdata,  32'h77);
    check("r1rd_r0rv", r0_rvalid, 0);

    // Hazard read of the LED register: accepted but never driven onto the bus
    r1_valid = 1; r1_write = 0; r1_addr = 32'hffff_ff0c; r1_wdata = 32'hdead; data_io = 32'h5a;
    #1 check("hz_ready", r1_ready, 1);
    tick();
    r1_valid = 0;
    check("hz_addr",  bus_addr,  32'h0);
    check("hz_wdata", bus_wdata, 32'h0);
    tick();
    check("hz_rv",    r1_rvalid, 1);
    check("hz_rd",    r1_rdata,  32'h0);
    check("hz_addr2", bus_addr,  32'h0);

    // Rejected address below the MMIO window
    r0_valid = 1; r0_write = 1; r0_addr = 32'h0000_1000; r0_wdata = 32'h99;
    #1 check("rj_ready", r0_ready, 1);
    tick();
    r0_valid = 0;
    check("rj_addr",  bus_addr,  32'h0);
    check("rj_wdata", bus_wdata, 32'h0);
    check("rj_rv0",   r0_rvalid, 0);
    tick();
    check("rj_rv",    r0_rvalid, 1);
    check("rj_rd",    r0_rdata,  32'h0);
    tick();

    // Asynchronous reset with a read in flight
    r0_valid = 1; r0_write = 0; r0_addr = 32'hffff_ff00; data_io = 32'h5a;
    tick();
    r0_valid = 0;
    check("mr_addr", bus_addr, 32'hffff_ff00);
    #1 reset = 1'b1;
    #1 check("mr_addr_now",  bus_addr,  32'h0);
    check("mr_rd_cleared", r0_rdata, 32'h0);
    r1_valid = 1; r1_write = 1; r1_addr = 32'hffff_ff0c; r1_wdata = 32'h5;
    #1 check("mr_ready_in_rst", r1_ready, 1);
    tick();
    check("mr_no_rv",      r0_rvalid, 0);
    check("mr_no_xfer",    bus_addr,  32'h0);
    r1_valid = 0;
    reset = 1'b0;
    tick();
    check("mr_no_rv2",     r0_rvalid, 0);
    check("mr_no_rv2_r1",  r1_rvalid, 0);
    r0_valid = 1; r0_write = 1; r0_addr = 32'hffff_ff0c; r0_wdata = 32'h22;
    r1_valid = 1; r1_write = 1; r1_addr = 32'hffff_e005; r1_wdata = 32'h41;
    #1 check("mr_tie_r0", r0_ready, 1);
    check("mr_tie_r1", r1_ready, 0);
    tick();
    idle_inputs();
    check("mr_tie_addr", bus_addr, 32'hffff_ff0c);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
